// File: rtl/gray_seq_ctrl_if.sv
// Control/status bundle between a Gray-counter sequencer and its user.
// The sequencer (slave) drives the counter controls and status flags.
interface gray_seq_ctrl_if #(
  parameter int WIDTH = 3,
  parameter int LEN_W = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len;
  logic             stop;
  logic             step;
  logic [WIDTH-1:0] gray_in;
  logic             cnt_en;
  logic             cnt_rst_n;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] steps_done;
  logic             err;

  modport master (
    output start, mode, len, stop, step, gray_in,
    input  cnt_en, cnt_rst_n, busy, done, steps_done, err
  );

  modport slave (
    input  start, mode, len, stop, step, gray_in,
    output cnt_en, cnt_rst_n, busy, done, steps_done, err
  );
endinterface

// File: rtl/gray_seq_ctrl.sv
// Run sequencer for an external Gray counter with an on-line
// sequence checker that flags illegal code transitions.
module gray_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int LEN_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  gray_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_STEP_EN, S_FIN
  } state_e;

  typedef enum logic [1:0] {
    M_FREE, M_COUNT, M_STEP
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] steps_q, steps_d;
  logic             err_q, err_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_rst_n_q, cnt_rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] gray_prev_q;
  logic             en_chk_q;
  logic             clr_chk_q;

  logic             go;
  logic             last;
  logic             fail;
  logic [LEN_W:0]   run_cnt;
  logic [WIDTH-1:0] diff;
  logic             one_bit;

  assign run_cnt = {1'b0, steps_q} + (LEN_W+1)'(1);
  assign last    = run_cnt >= {1'b0, len_q};

  assign diff    = bus.gray_in ^ gray_prev_q;
  assign one_bit = (diff != '0) &&
                   ((diff & (diff - WIDTH'(1))) == '0);

  always_comb begin
    fail = 1'b0;
    if (armed_q) begin
      if (clr_chk_q)     fail = bus.gray_in != '0;
      else if (en_chk_q) fail = !one_bit;
      else               fail = diff != '0;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          go      = 1'b1;
          state_d = S_CLEAR;
          len_d   = bus.len;
          unique case (1'b1)
            bus.mode == 2'b00: mode_d = M_FREE;
            bus.mode == 2'b10: mode_d = M_STEP;
            default:           mode_d = M_COUNT;
          endcase
        end
      end
      S_CLEAR: begin
        if (mode_q == M_COUNT && len_q == '0) state_d = S_FIN;
        else                                  state_d = S_RUN;
      end
      S_RUN: begin
        unique case (mode_q)
          M_COUNT: if (last) state_d = S_FIN;
          M_FREE:  if (bus.stop) state_d = S_FIN;
          default: begin
            if (bus.stop)      state_d = S_FIN;
            else if (bus.step) state_d = S_STEP_EN;
          end
        endcase
      end
      S_STEP_EN: state_d = S_RUN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step.
  always_comb begin
    steps_d = steps_q;
    if (cnt_en_q && steps_q != '1) steps_d = steps_q + LEN_W'(1);
    if (go) steps_d = '0;
    err_d       = go ? 1'b0 : (err_q | fail);
    armed_d     = armed_q | ~cnt_rst_n_q;
    cnt_en_d    = (state_d == S_RUN && mode_q != M_STEP) ||
                  state_d == S_STEP_EN;
    cnt_rst_n_d = state_d != S_CLEAR;
    busy_d      = state_d != S_IDLE;
    done_d      = state_d == S_FIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= M_FREE;
      len_q       <= '0;
      steps_q     <= '0;
      err_q       <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      armed_q     <= 1'b0;
      gray_prev_q <= '0;
      en_chk_q    <= 1'b0;
      clr_chk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      steps_q     <= steps_d;
      err_q       <= err_d;
      cnt_en_q    <= cnt_en_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      armed_q     <= armed_d;
      gray_prev_q <= bus.gray_in;
      en_chk_q    <= cnt_en_q;
      clr_chk_q   <= ~cnt_rst_n_q;
    end
  end

  assign bus.cnt_en     = cnt_en_q;
  assign bus.cnt_rst_n  = cnt_rst_n_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps_done = steps_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: Gray counter model plus a run scoreboard
// checked on every done pulse.
module tb_gray_seq_ctrl;
  localparam int WIDTH = 3;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_seq_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  gray_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [WIDTH-1:0] bin_q = '0;
  logic             inj = 1'b0;

  // inj makes the counter jump 011 -> 110, skipping code 010
  always @(posedge clk) begin
    if (!bus.cnt_rst_n)  bin_q <= '0;
    else if (bus.cnt_en) bin_q <= bin_q +
      ((inj && bin_q == 3'd2) ? 3'd2 : 3'd1);
  end
  assign bus.gray_in = bin_q ^ (bin_q >> 1);

  typedef struct {
    int steps;
    int ens;
    int err;
    int gray;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   en_seen = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.cnt_en === 1'b1) en_seen++;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_steps", bus.steps_done, e.steps);
        chk("sb_ens", en_seen, e.ens);
        chk("sb_err", bus.err, e.err);
        chk("sb_gray", bus.gray_in, e.gray);
      end
    end
  end

  task automatic push(input int s, input int n,
                      input int e, input int g);
    exp_t x;
    x.steps = s;
    x.ens   = n;
    x.err   = e;
    x.gray  = g;
    sb.push_back(x);
  endtask

  task automatic begin_run(input logic [1:0] m, input int n);
    @(negedge clk);
    en_seen   = 0;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.len   = LEN_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", bus.done, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, bus.cnt_en, 0);
    chk({tag, "_crst"}, bus.cnt_rst_n, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_steps"}, bus.steps_done, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int k;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.len   = '0;
    bus.stop  = 1'b0;
    bus.step  = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // COUNT_N len=5
    push(5, 5, 0, 3'b111);
    begin_run(2'b01, 5);
    chk("clr_crst", bus.cnt_rst_n, 0);
    chk("clr_en", bus.cnt_en, 0);
    chk("clr_busy", bus.busy, 1);
    wait_done();
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("hold_steps", bus.steps_done, 5);

    // COUNT_N len=9 wraps the 3-bit counter once
    push(9, 9, 0, 3'b001);
    begin_run(2'b01, 9);
    wait_done();

    // mode 11 with len=0 goes straight to FIN
    push(0, 0, 0, 3'b000);
    begin_run(2'b11, 0);
    @(negedge clk);
    chk("len0_done", bus.done, 1);

    // FREE, stop during the third enable, start while busy
    push(3, 3, 0, 3'b010);
    begin_run(2'b00, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    bus.len   = LEN_W'(1);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("free_en3", bus.cnt_en, 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("free_done", bus.done, 1);

    // STEP: three pulses then step+stop together
    push(3, 3, 0, 3'b010);
    begin_run(2'b10, 0);
    @(negedge clk);
    chk("step_run_en", bus.cnt_en, 0);
    repeat (3) begin
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    bus.step = 1'b1;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    bus.stop = 1'b0;
    chk("step_done", bus.done, 1);

    // skipped Gray code raises err, held through FIN
    inj = 1'b1;
    push(4, 4, 1, 3'b111);
    begin_run(2'b01, 4);
    wait_done();
    inj = 1'b0;
    push(1, 1, 0, 3'b001);
    begin_run(2'b01, 1);
    chk("err_cleared", bus.err, 0);
    wait_done();

    // async reset in the middle of a COUNT_N run
    begin_run(2'b01, 20);
    c = 0;
    k = 0;
    while (c < 4 && k < 50) begin
      @(negedge clk);
      if (bus.cnt_en === 1'b1) c++;
      k++;
    end
    chk("pre_rst_ens", c, 4);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    rst_n     = 1'b1;
    en_seen   = 0;
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    bus.len   = LEN_W'(20);
    push(20, 20, 0, 3'b110);
    @(negedge clk);
    bus.start = 1'b0;
    chk("rerun_busy", bus.busy, 1);
    chk("rerun_crst", bus.cnt_rst_n, 0);
    wait_done();

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
